dmac_xfer_datapath: RTL and testbench
=====================================

Name: dmac_xfer_datapath

Overview:
- Channel datapath that sits beside the channel controller FSM in the DMA channel.
- Holds the source address, destination address, remaining transfer size, current burst length and beat counter.
- Consumes the controller's select/enable strobes; produces the status flags the FSM branches on (bsz, tsz, tslb) and the AHB master address/control outputs.
- One instance per channel; purely synchronous apart from reset.

Parameters:
ADDR_W, 32, address width of src/dst registers and M_HAddr
TS_W, 16, width of transfer-size (beat count) register
BL_W, 5, width of burst-length register and beat counter (max burst 16)

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_src_addr  in  ADDR_W  programmed source start address
cfg_dst_addr  in  ADDR_W  programmed destination start address
cfg_trans_size  in  TS_W  total beats to move
cfg_burst_len  in  BL_W  beats per burst, 1..16
cfg_hsize  in  2  beat size: 0=byte, 1=half, 2=word
cfg_src_inc  in  1  1=increment source address, 0=fixed
cfg_dst_inc  in  1  1=increment destination address, 0=fixed
t_sel, s_sel, d_sel, b_sel, h_sel  in  1 each  load/select strobes from controller
ts_en, s_en, d_en, burst_en, count_en  in  1 each  register enables from controller
write  in  1  controller write phase
M_HResp  in  2  AHB response
bsz  out  1  current burst phase complete
tsz  out  1  remaining transfer size is zero
tslb  out  1  remaining size nonzero and less than burst length
M_HAddr  out  ADDR_W  AHB address
M_HWrite  out  1  AHB write
M_HSize  out  3  AHB size, {1'b0, cfg_hsize}
err  out  1  sticky bus-error flag

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. On reset, src_addr, dst_addr, ts_rem, burst_len, beat_cnt and err are cleared to 0. Resulting outputs: bsz=0, tsz=1, tslb=0, M_HAddr=0, err=0.
- Transfer-size register (ts_rem):
  - ts_en & t_sel: ts_rem <= cfg_trans_size.
  - ts_en & !t_sel: ts_rem <= ts_rem - burst_len, saturating at 0 (no wrap).
- Burst-length register (burst_len):
  - burst_en & !b_sel: burst_len <= cfg_burst_len.
  - burst_en & b_sel: burst_len <= ts_rem[BL_W-1:0]. Uses the pre-update ts_rem; only legal when tslb=1.
- Beat counter (beat_cnt):
  - burst_en & count_en: beat_cnt <= 1.
  - burst_en alone: beat_cnt <= 0.
  - count_en & bsz: beat_cnt <= 1 (first beat of next phase).
  - count_en alone: beat_cnt <= beat_cnt + 1.
  - Priority: burst_en over count_en.
- Source address (src_addr):
  - s_en & s_sel: src_addr <= cfg_src_addr.
  - s_en & !s_sel & cfg_src_inc: src_addr <= src_addr + (1<<cfg_hsize).
  - s_en & !s_sel & !cfg_src_inc: src_addr holds.
  - Address wraps modulo 2^ADDR_W.
- Destination address (dst_addr): same rules as src_addr, using d_en, d_sel, cfg_dst_addr, cfg_dst_inc.
- Status flags (combinational from registers):
  - bsz = (burst_len != 0) && (beat_cnt == burst_len).
  - tsz = (ts_rem == 0).
  - tslb = (ts_rem != 0) && (ts_rem < burst_len).
- AHB outputs:
  - M_HAddr = h_sel ? dst_addr : src_addr, combinational. It shows the pre-increment value in the cycle where the enable is asserted, so the address phase carries the current beat.
  - M_HWrite = write.
  - M_HSize = {1'b0, cfg_hsize}.
- Error flag: err sets when M_HResp != 0 at a clock edge. It clears only on reset, or when ts_en & t_sel occurs (new transfer load).
- Simultaneous load and increment of the same register cannot occur: the sel bit decides the operation.
- cfg_* inputs are only sampled on load strobes; they may change mid-transfer without effect.
- Reset mid-transfer: all state cleared immediately; outputs return to reset values in the same cycle.

Test Plan:
1. Init: cfg_trans_size=8, cfg_burst_len=4, src=0x1000, dst=0x2000, hsize=2. Pulse t_sel/s_sel/d_sel/burst_en/ts_en/s_en/d_en -> ts_rem=8, burst_len=4, beat_cnt=0, tsz=0, tslb=0, M_HAddr=0x1000.
2. Four count_en+s_en cycles -> M_HAddr sequence 0x1000, 0x1004, 0x1008, 0x100C; bsz=1 after the 4th. Then h_sel=1 + ts_en + count_en + d_en -> ts_rem=4, beat_cnt=1, M_HAddr=0x2000.
3. Short tail: trans_size=6, burst_len=4; after the first burst ts_en -> ts_rem=2, tslb=1. burst_en+b_sel+count_en -> burst_len=2, beat_cnt=1. One more count_en -> bsz=1.
4. Saturation: ts_rem=2, burst_len=4, ts_en & !t_sel -> ts_rem=0, tsz=1 (no wrap to 0xFFFE).
5. Fixed address: cfg_src_inc=0, hsize=1, 3 s_en increments -> src_addr stays 0x3000. Address wrap: dst=0xFFFFFFFC, hsize=2, d_en -> 0x00000000.
6. M_HResp=2'b01 for one cycle -> err=1 and holds. Assert rst mid-burst -> all registers zero, tsz=1, bsz=0, err=0 immediately.

Source files
------------

// File: rtl/dmac_xfer_datapath.sv
// DMA channel transfer datapath: address, size, burst and beat registers plus the
// status flags and AHB address/control outputs used by the channel controller.
module dmac_xfer_datapath #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned BL_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_src_addr,
  input  logic [ADDR_W-1:0] cfg_dst_addr,
  input  logic [TS_W-1:0]   cfg_trans_size,
  input  logic [BL_W-1:0]   cfg_burst_len,
  input  logic [1:0]        cfg_hsize,
  input  logic              cfg_src_inc,
  input  logic              cfg_dst_inc,
  input  logic              t_sel,
  input  logic              s_sel,
  input  logic              d_sel,
  input  logic              b_sel,
  input  logic              h_sel,
  input  logic              ts_en,
  input  logic              s_en,
  input  logic              d_en,
  input  logic              burst_en,
  input  logic              count_en,
  input  logic              write,
  input  logic [1:0]        M_HResp,
  output logic              bsz,
  output logic              tsz,
  output logic              tslb,
  output logic [ADDR_W-1:0] M_HAddr,
  output logic              M_HWrite,
  output logic [2:0]        M_HSize,
  output logic              err
);

  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [TS_W-1:0]   ts_rem_q, ts_rem_d;
  logic [BL_W-1:0]   burst_len_q, burst_len_d;
  logic [BL_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;

  logic [TS_W-1:0]   burst_len_ext;
  logic [ADDR_W-1:0] addr_step;

  assign burst_len_ext = TS_W'(burst_len_q);
  assign addr_step     = ADDR_W'(1) << cfg_hsize;

  assign bsz  = (burst_len_q != '0) && (beat_cnt_q == burst_len_q);
  assign tsz  = (ts_rem_q == '0);
  assign tslb = (ts_rem_q != '0) && (ts_rem_q < burst_len_ext);

  // Address phase shows the current (pre-increment) beat address.
  assign M_HAddr  = h_sel ? dst_addr_q : src_addr_q;
  assign M_HWrite = write;
  assign M_HSize  = {1'b0, cfg_hsize};
  assign err      = err_q;

  always_comb begin
    ts_rem_d = ts_rem_q;
    if (ts_en) begin
      if (t_sel) begin
        ts_rem_d = cfg_trans_size;
      end else if (ts_rem_q < burst_len_ext) begin
        ts_rem_d = '0;
      end else begin
        ts_rem_d = ts_rem_q - burst_len_ext;
      end
    end
  end

  always_comb begin
    burst_len_d = burst_len_q;
    if (burst_en) begin
      burst_len_d = b_sel ? ts_rem_q[BL_W-1:0] : cfg_burst_len;
    end
  end

  // A new burst started together with a beat counts that beat as the first one.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (burst_en) begin
      beat_cnt_d = count_en ? BL_W'(1) : '0;
    end else if (count_en) begin
      beat_cnt_d = bsz ? BL_W'(1) : beat_cnt_q + BL_W'(1);
    end
  end

  always_comb begin
    src_addr_d = src_addr_q;
    if (s_en) begin
      if (s_sel) begin
        src_addr_d = cfg_src_addr;
      end else if (cfg_src_inc) begin
        src_addr_d = src_addr_q + addr_step;
      end
    end
  end

  always_comb begin
    dst_addr_d = dst_addr_q;
    if (d_en) begin
      if (d_sel) begin
        dst_addr_d = cfg_dst_addr;
      end else if (cfg_dst_inc) begin
        dst_addr_d = dst_addr_q + addr_step;
      end
    end
  end

  // An error response on the load cycle itself is still recorded.
  always_comb begin
    err_d = err_q;
    if (ts_en && t_sel) begin
      err_d = 1'b0;
    end
    if (M_HResp != 2'b00) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      ts_rem_q    <= '0;
      burst_len_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      src_addr_q  <= src_addr_d;
      dst_addr_q  <= dst_addr_d;
      ts_rem_q    <= ts_rem_d;
      burst_len_q <= burst_len_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_dmac_xfer_datapath.sv
// Directed bench for dmac_xfer_datapath: expected values are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_dmac_xfer_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_src_addr, cfg_dst_addr;
  logic [15:0] cfg_trans_size;
  logic [4:0]  cfg_burst_len;
  logic [1:0]  cfg_hsize;
  logic        cfg_src_inc, cfg_dst_inc;
  logic        t_sel, s_sel, d_sel, b_sel, h_sel;
  logic        ts_en, s_en, d_en, burst_en, count_en;
  logic        write;
  logic [1:0]  M_HResp;
  logic        bsz, tsz, tslb, M_HWrite, err;
  logic [31:0] M_HAddr;
  logic [2:0]  M_HSize;

  int total = 0;
  int bad   = 0;
  string       tag_q[$];
  logic [63:0] val_q[$];

  dmac_xfer_datapath #(.ADDR_W(32), .TS_W(16), .BL_W(5)) dut (
    .clk(clk), .rst(rst),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
    .cfg_trans_size(cfg_trans_size), .cfg_burst_len(cfg_burst_len),
    .cfg_hsize(cfg_hsize), .cfg_src_inc(cfg_src_inc), .cfg_dst_inc(cfg_dst_inc),
    .t_sel(t_sel), .s_sel(s_sel), .d_sel(d_sel), .b_sel(b_sel), .h_sel(h_sel),
    .ts_en(ts_en), .s_en(s_en), .d_en(d_en), .burst_en(burst_en), .count_en(count_en),
    .write(write), .M_HResp(M_HResp),
    .bsz(bsz), .tsz(tsz), .tslb(tslb), .M_HAddr(M_HAddr), .M_HWrite(M_HWrite),
    .M_HSize(M_HSize), .err(err)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic chk(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    total++;
    if (val_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic idle();
    {t_sel, s_sel, d_sel, b_sel, h_sel} = '0;
    {ts_en, s_en, d_en, burst_en, count_en} = '0;
    M_HResp = 2'b00;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic b, input logic z, input logic l);
    push({tag, "_bsz"}, 64'(b));
    push({tag, "_tsz"}, 64'(z));
    push({tag, "_tslb"}, 64'(l));
    #1;
    chk(64'(bsz));
    chk(64'(tsz));
    chk(64'(tslb));
  endtask

  initial begin
    rst = 1'b0;
    idle();
    write = 1'b0;
    cfg_src_addr = 32'h0; cfg_dst_addr = 32'h0;
    cfg_trans_size = 16'd0; cfg_burst_len = 5'd0;
    cfg_hsize = 2'd2; cfg_src_inc = 1'b1; cfg_dst_inc = 1'b1;
    #1 rst = 1'b1;
    flags("reset", 1'b0, 1'b1, 1'b0);
    push("reset_addr", 64'h0); push("reset_err", 64'h0); push("reset_hsize", 64'h2);
    chk(64'(M_HAddr)); chk(64'(err)); chk(64'(M_HSize));
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Initial load of all registers.
    cfg_trans_size = 16'd8; cfg_burst_len = 5'd4;
    cfg_src_addr = 32'h1000; cfg_dst_addr = 32'h2000;
    t_sel = 1; ts_en = 1; s_sel = 1; s_en = 1; d_sel = 1; d_en = 1; burst_en = 1;
    cyc(); idle();
    flags("init", 1'b0, 1'b0, 1'b0);
    push("init_addr", 64'h1000); chk(64'(M_HAddr));

    // Cfg changes without strobes must not affect state.
    cfg_src_addr = 32'hDEAD0000;
    push("cfg_ignored", 64'h1000); #1 chk(64'(M_HAddr));

    // First burst: address phase shows the pre-increment address.
    for (int i = 0; i < 4; i++) push("burst_addr", 64'h1000 + 64'(4 * i));
    for (int i = 0; i < 4; i++) begin
      count_en = 1; s_en = 1;
      #1 chk(64'(M_HAddr));
      cyc();
    end
    idle();
    push("burst_done", 64'h1); #1 chk(64'(bsz));

    h_sel = 1; ts_en = 1; count_en = 1; d_en = 1;
    push("dst_addr", 64'h2000); #1 chk(64'(M_HAddr));
    cyc(); idle(); h_sel = 1;
    push("dst_inc", 64'h2004); #1 chk(64'(M_HAddr));
    h_sel = 0;
    push("src_after", 64'h1010); #1 chk(64'(M_HAddr));
    flags("phase2", 1'b0, 1'b0, 1'b0);

    // Short tail burst.
    cfg_trans_size = 16'd6; cfg_burst_len = 5'd4;
    t_sel = 1; ts_en = 1; burst_en = 1;
    cyc(); idle();
    flags("tail_load", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      count_en = 1;
      cyc();
    end
    idle();
    ts_en = 1;
    cyc(); idle();
    flags("tail_rem", 1'b1, 1'b0, 1'b1);
    burst_en = 1; b_sel = 1; count_en = 1;
    cyc(); idle();
    flags("tail_burst", 1'b0, 1'b0, 1'b0);
    count_en = 1;
    cyc(); idle();
    flags("tail_end", 1'b1, 1'b0, 1'b0);

    // Saturating subtract.
    cfg_trans_size = 16'd2; cfg_burst_len = 5'd4;
    t_sel = 1; ts_en = 1; burst_en = 1;
    cyc(); idle();
    flags("sat_load", 1'b0, 1'b0, 1'b1);
    ts_en = 1;
    cyc(); idle();
    flags("sat_zero", 1'b0, 1'b1, 1'b0);

    // Fixed source address, then incrementing with half and byte sizes.
    cfg_src_addr = 32'h3000; cfg_hsize = 2'd1; cfg_src_inc = 0;
    s_sel = 1; s_en = 1;
    cyc(); idle();
    for (int i = 0; i < 3; i++) begin
      s_en = 1;
      cyc();
    end
    idle();
    push("fixed_addr", 64'h3000); push("hsize_half", 64'h1);
    #1 chk(64'(M_HAddr)); chk(64'(M_HSize));
    cfg_src_inc = 1; s_en = 1;
    cyc(); idle();
    push("inc_half", 64'h3002); #1 chk(64'(M_HAddr));
    cfg_hsize = 2'd0; s_en = 1;
    cyc(); idle();
    push("inc_byte", 64'h3003); #1 chk(64'(M_HAddr));

    // Destination wrap.
    cfg_dst_addr = 32'hFFFF_FFFC; cfg_hsize = 2'd2; cfg_dst_inc = 1;
    d_sel = 1; d_en = 1;
    cyc(); idle();
    d_en = 1;
    cyc(); idle(); h_sel = 1;
    push("dst_wrap", 64'h0); #1 chk(64'(M_HAddr));
    h_sel = 0;

    write = 1;
    push("hwrite", 64'h1); #1 chk(64'(M_HWrite));
    write = 0;

    // Sticky error, cleared by a new transfer load.
    M_HResp = 2'b01;
    cyc(); idle();
    push("err_set", 64'h1); #1 chk(64'(err));
    cyc();
    push("err_hold", 64'h1); #1 chk(64'(err));
    cfg_trans_size = 16'd8; cfg_burst_len = 5'd4;
    t_sel = 1; ts_en = 1; burst_en = 1;
    cyc(); idle();
    push("err_clear", 64'h0); #1 chk(64'(err));

    // Reset in the middle of a burst.
    M_HResp = 2'b10;
    count_en = 1;
    cyc(); idle();
    count_en = 1;
    cyc(); idle();
    push("err_pre_rst", 64'h1); #1 chk(64'(err));
    rst = 1'b1;
    flags("mid_rst", 1'b0, 1'b1, 1'b0);
    push("mid_rst_err", 64'h0); push("mid_rst_src", 64'h0);
    chk(64'(err)); chk(64'(M_HAddr));
    h_sel = 1;
    push("mid_rst_dst", 64'h0); #1 chk(64'(M_HAddr));
    h_sel = 0;
    cyc();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
